// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int OVS       = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // Clocks per oversample tick (integer division, truncating).
    function automatic int calc_tick_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// rtl/uart_rx_baud_tick_gen.sv - oversample tick generator with phase-align clear
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   clr  - restart the divider at 0 (aligns tick phase to a frame start)
//   tick - one-clock pulse every TICK_DIV clocks
module baud_tick_gen #(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear wins over a coincident terminal count so the new phase starts clean.
    assign tick = ~clr & (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and mid-bit sampling
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   rx        - serial line, idle high, asynchronous to clk
//   rx_data   - last correctly received byte (LSB = first data bit on the line)
//   rx_done   - one-clock pulse when rx_data has just been updated
//   rx_busy   - high from start-bit acceptance until the frame finishes or aborts
//   frame_err - one-clock pulse when the stop bit samples low
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVS);
    localparam int SW       = $clog2(OVS);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    // Synchronizer and edge detection.
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_prev_q;
    logic [1:0] settle_q;
    logic [1:0] settle_d;
    logic       armed_q;
    logic       armed_d;
    logic       fall;

    // Receiver state.
    uart_state_e   state_q;
    uart_state_e   state_d;
    logic [SW-1:0] samp_q;
    logic [SW-1:0] samp_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          done_q;
    logic          done_d;
    logic          ferr_q;
    logic          ferr_d;
    logic          tick_clr;
    logic          tick;

    // After reset the synchronizer holds 1s that do not reflect the line. Edge
    // detection is armed only once the synchronized line has been seen high
    // after the chain has refilled, so a line held low across reset release
    // does not look like a start edge.
    always_comb begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & rx_s_q);
    end

    assign fall = armed_q & rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
        end
    end

    baud_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_comb begin
        state_d  = state_q;
        samp_d   = samp_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        tick_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d  = START;
                    samp_d   = '0;
                    bit_d    = '0;
                    tick_clr = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    if (samp_q == SAMP_MID) begin
                        samp_d  = '0;
                        // A line back high at mid start bit was a glitch.
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end

            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
